phy_tx_link_ctrl: RTL and testbench
===================================

// Module: phy_tx_link_ctrl
// PURPOSE
//  Link bring-up sequencer for the PHY transmit path. Watches the deserialized byte stream returned
//  from the far end and decides when the TX datapath may send real data.
//  Drives `active`, which gates the recirculator, and `send_com`, which forces COM fill while unlocked.
//  Counts comma (BC) symbols to lock and tracks idle (7C) periods.
//  Drops lock on byte-strobe timeout or a resync request.
// PARAMETERS
//  SYNC_COUNT  4      consecutive COM bytes required to lock (1..7)
//  COM_SYM     8'hBC  comma symbol
//  IDL_SYM     8'h7C  idle symbol
//  TIMEOUT     32     max clk_4f cycles between rx_byte_valid strobes while locked (2..63)
// PORTS
//  clk_4f         in   1  sole clock; all logic on its rising edge
//  reset          in   1  synchronous, active-high
//  rx_byte        in   8  deserialized byte; sampled only when rx_byte_valid=1
//  rx_byte_valid  in   1  one-cycle strobe per received byte
//  force_resync   in   1  level; while 1, FSM returns to/holds SEARCH
//  active         out  1  1 = link locked, TX datapath may send lane data
//  idle_out       out  1  1 = locked and far end currently sending IDL_SYM
//  send_com       out  1  1 = TX must transmit COM_SYM fill (= ~active)
//  state_out      out  2  00 SEARCH, 01 LOCKED, 10 IDLE, 11 unused
//  com_cnt        out  3  current consecutive-COM count
//  resync_cnt     out  8  number of lock losses since reset, saturates at 255
// BEHAVIOUR
//  Reset:
//   - all outputs registered
//   - in a cycle with reset=1, next state = SEARCH: active=0, idle_out=0, send_com=1,
//     com_cnt=0, resync_cnt=0, timer=0
//  SEARCH:
//   - rx_byte_valid & rx_byte==COM_SYM: com_cnt++
//   - rx_byte_valid & other byte: com_cnt<=0
//   - when the strobe that brings the count to SYNC_COUNT arrives: next state LOCKED, com_cnt<=0;
//     active=1 and send_com=0 visible the cycle after that strobe (1-cycle latency)
//   - cycles without a strobe leave com_cnt unchanged
//  LOCKED:
//   - rx_byte_valid & rx_byte==IDL_SYM -> IDLE (idle_out=1 next cycle)
//   - COM and data bytes keep LOCKED; com_cnt held at 0
//  IDLE:
//   - active stays 1
//   - rx_byte_valid & byte!=IDL_SYM -> LOCKED, idle_out<=0
//  Timer (LOCKED/IDLE only):
//   - clears to 0 on every rx_byte_valid, else increments
//   - on the cycle timer==TIMEOUT-1 with no strobe -> SEARCH, resync_cnt++
//   - timer held at 0 in SEARCH
//  force_resync:
//   - in LOCKED/IDLE -> SEARCH next cycle, resync_cnt++ (once per lock loss, not per cycle)
//   - while held: stays in SEARCH, com_cnt forced to 0 (locking inhibited)
//  Priority, highest first: reset > force_resync > timeout > byte decode
//   - a strobe in the same cycle as timer==TIMEOUT-1 counts as arrival; no timeout
//  resync_cnt saturates at 255; it never wraps
//  State encoding 11 is unreachable; if entered, next state = SEARCH (no resync_cnt change)
//  reset mid-lock: active drops the cycle after reset is sampled and resync_cnt clears
//   - reset is not counted as a lock loss
// TESTING
//  T1 reset 3 cycles -> active=0, send_com=1, state_out=00, resync_cnt=0
//  T2 four BC strobes, 8 cycles apart -> active=1 one cycle after 4th strobe; com_cnt 1,2,3, then 0
//  T3 BC,BC,BC,0x55,BC x4 -> lock only after final 4th consecutive BC; com_cnt returns to 0 at 0x55
//  T4 locked, send 7C,7C,0xA5 -> idle_out 1 after first 7C, back to 0 after 0xA5; active stays 1
//  T5 locked, stop strobes -> SEARCH after 32 cycles, resync_cnt=1;
//     strobe on cycle 31 -> no timeout
//  T6 force_resync pulse while locked -> SEARCH next cycle, resync_cnt+1; held high with BC x8 -> no lock

Source files
------------

// File: rtl/phy_tx_link_ctrl.sv
// Link bring-up sequencer: locks after SYNC_COUNT consecutive commas and drops lock on strobe timeout or resync.
// All outputs are registered and update one cycle after the deciding strobe. There is no backpressure: every strobe is consumed.
module phy_tx_link_ctrl #(
   parameter int unsigned SYNC_COUNT = 4,
   parameter logic [7:0]  COM_SYM    = 8'hBC,
   parameter logic [7:0]  IDL_SYM    = 8'h7C,
   parameter int unsigned TIMEOUT    = 32
) (
   input  logic       i_clk_4f,
   input  logic       i_reset,
   input  logic [7:0] i_rx_byte,
   input  logic       i_rx_byte_valid,
   input  logic       i_force_resync,
   output logic       o_active,
   output logic       o_idle_out,
   output logic       o_send_com,
   output logic [1:0] o_state_out,
   output logic [2:0] o_com_cnt,
   output logic [7:0] o_resync_cnt
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_LOCKED = 2'b01,
      ST_IDLE   = 2'b10,
      ST_UNUSED = 2'b11
   } state_t;

   localparam logic [2:0] SYNC_LAST  = 3'(SYNC_COUNT - 1);
   localparam logic [5:0] TIMER_LAST = 6'(TIMEOUT - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_com_cnt;
   logic [2:0] w_com_cnt_nxt;
   logic [5:0] r_timer;
   logic [5:0] w_timer_nxt;
   logic [7:0] r_resync_cnt;
   logic       r_active;
   logic       r_idle_out;
   logic       r_send_com;
   logic       w_loss;
   logic       w_locked_nxt;

   always_comb begin
      w_state_nxt   = r_state;
      w_com_cnt_nxt = r_com_cnt;
      w_timer_nxt   = r_timer;
      w_loss        = 1'b0;
      case (r_state)
         ST_SEARCH: begin
            w_timer_nxt = '0;
            if (i_force_resync) begin
               w_com_cnt_nxt = '0;
            end else if (i_rx_byte_valid) begin
               if (i_rx_byte == COM_SYM) begin
                  if (r_com_cnt == SYNC_LAST) begin
                     w_state_nxt   = ST_LOCKED;
                     w_com_cnt_nxt = '0;
                  end else begin
                     w_com_cnt_nxt = r_com_cnt + 3'd1;
                  end
               end else begin
                  w_com_cnt_nxt = '0;
               end
            end
         end
         ST_LOCKED, ST_IDLE: begin
            w_com_cnt_nxt = '0;
            // A strobe on the last timer cycle counts as arrival, so it is tested before expiry.
            if (i_force_resync) begin
               w_state_nxt = ST_SEARCH;
               w_timer_nxt = '0;
               w_loss      = 1'b1;
            end else if (i_rx_byte_valid) begin
               w_timer_nxt = '0;
               w_state_nxt = (i_rx_byte == IDL_SYM) ? ST_IDLE : ST_LOCKED;
            end else if (r_timer == TIMER_LAST) begin
               w_state_nxt = ST_SEARCH;
               w_timer_nxt = '0;
               w_loss      = 1'b1;
            end else begin
               w_timer_nxt = r_timer + 6'd1;
            end
         end
         default: begin
            w_state_nxt   = ST_SEARCH;
            w_com_cnt_nxt = '0;
            w_timer_nxt   = '0;
         end
      endcase
   end

   assign w_locked_nxt = (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_IDLE);

   always_ff @(posedge i_clk_4f) begin
      if (i_reset) begin
         r_state      <= ST_SEARCH;
         r_com_cnt    <= '0;
         r_timer      <= '0;
         r_resync_cnt <= '0;
         r_active     <= 1'b0;
         r_idle_out   <= 1'b0;
         r_send_com   <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_com_cnt  <= w_com_cnt_nxt;
         r_timer    <= w_timer_nxt;
         r_active   <= w_locked_nxt;
         r_idle_out <= (w_state_nxt == ST_IDLE);
         r_send_com <= ~w_locked_nxt;
         if (w_loss && (r_resync_cnt != 8'hFF)) begin
            r_resync_cnt <= r_resync_cnt + 8'd1;
         end
      end
   end

   assign o_active     = r_active;
   assign o_idle_out   = r_idle_out;
   assign o_send_com   = r_send_com;
   assign o_state_out  = r_state;
   assign o_com_cnt    = r_com_cnt;
   assign o_resync_cnt = r_resync_cnt;

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Bench for phy_tx_link_ctrl: vector table, hand-written timing corners, then random traffic against a link model.
module tb_phy_tx_link_ctrl;

   localparam int         SYNC = 4;
   localparam int         TMO  = 32;
   localparam logic [7:0] COM  = 8'hBC;
   localparam logic [7:0] IDL  = 8'h7C;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_byte;
   logic       rx_vld;
   logic       frc;
   logic       active, idle_out, send_com;
   logic [1:0] state_out;
   logic [2:0] com_cnt;
   logic [7:0] resync_cnt;

   always #5 clk = ~clk;

   phy_tx_link_ctrl dut (
      .i_clk_4f        (clk),
      .i_reset         (reset),
      .i_rx_byte       (rx_byte),
      .i_rx_byte_valid (rx_vld),
      .i_force_resync  (frc),
      .o_active        (active),
      .o_idle_out      (idle_out),
      .o_send_com      (send_com),
      .o_state_out     (state_out),
      .o_com_cnt       (com_cnt),
      .o_resync_cnt    (resync_cnt)
   );

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] dat;
      logic       frc;
      int         gap;
      logic       e_act;
      logic       e_idl;
      logic [1:0] e_st;
      logic [2:0] e_cnt;
      logic [7:0] e_rs;
   } vec_t;

   vec_t tbl[$];

   // Link model: lock flag, far-end idle flag, comma run length, silent cycles, loss count.
   bit m_locked;
   bit m_idle;
   int m_run;
   int m_silent;
   int m_losses;

   function automatic void add(input logic rst, input logic vld, input logic [7:0] dat, input logic f,
                               input int gap, input logic a, input logic i, input logic [1:0] st,
                               input logic [2:0] c, input logic [7:0] rs);
      vec_t v;
      v.rst = rst; v.vld = vld; v.dat = dat; v.frc = f; v.gap = gap;
      v.e_act = a; v.e_idl = i; v.e_st = st; v.e_cnt = c; v.e_rs = rs;
      tbl.push_back(v);
   endfunction

   function automatic logic [15:0] pk(input logic a, input logic i, input logic s, input logic [1:0] st,
                                      input logic [2:0] c, input logic [7:0] rs);
      return {a, i, s, st, c, rs};
   endfunction

   function automatic void lose_lock();
      m_locked = 1'b0;
      m_idle   = 1'b0;
      m_run    = 0;
      m_silent = 0;
      if (m_losses < 255) m_losses = m_losses + 1;
   endfunction

   function automatic void model_step(input logic rst, input logic vld, input logic [7:0] dat, input logic f);
      if (rst) begin
         m_locked = 1'b0; m_idle = 1'b0; m_run = 0; m_silent = 0; m_losses = 0;
      end else if (!m_locked) begin
         if (f) m_run = 0;
         else if (vld) begin
            if (dat == COM) begin
               m_run = m_run + 1;
               if (m_run == SYNC) begin
                  m_locked = 1'b1; m_run = 0; m_silent = 0; m_idle = 1'b0;
               end
            end else m_run = 0;
         end
      end else if (f) begin
         lose_lock();
      end else if (vld) begin
         m_silent = 0;
         m_idle   = (dat == IDL);
      end else begin
         m_silent = m_silent + 1;
         if (m_silent == TMO) lose_lock();
      end
   endfunction

   function automatic logic [15:0] model_exp();
      logic [1:0] st;
      logic [2:0] c;
      st = m_locked ? (m_idle ? 2'd2 : 2'd1) : 2'd0;
      c  = m_run[2:0];
      return pk(m_locked, m_locked && m_idle, !m_locked, st, c, m_losses[7:0]);
   endfunction

   function automatic logic [15:0] got();
      return pk(active, idle_out, send_com, state_out, com_cnt, resync_cnt);
   endfunction

   task automatic cyc(input logic rst, input logic vld, input logic [7:0] dat, input logic f);
      reset = rst; rx_vld = vld; rx_byte = dat; frc = f;
      @(posedge clk);
      #1;
      model_step(rst, vld, dat, f);
   endtask

   task automatic chk(input string nm, input logic [15:0] g, input logic [15:0] e);
      n_checks++;
      if (g !== e) begin
         n_err++;
         $display("FAIL %s: got act/idl/com/st/cnt/rs=%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%0d/%0d",
                  nm, g[15], g[14], g[13], g[12:11], g[10:8], g[7:0],
                  e[15], e[14], e[13], e[12:11], e[10:8], e[7:0]);
      end
   endtask

   task automatic chk_exp(input string nm, input logic a, input logic i, input logic [1:0] st,
                          input logic [2:0] c, input logic [7:0] rs);
      chk(nm, got(), pk(a, i, !a, st, c, rs));
   endtask

   task automatic lock4();
      repeat (SYNC) cyc(1'b0, 1'b1, COM, 1'b0);
   endtask

   initial begin
      reset = 1'b1; rx_vld = 1'b0; rx_byte = 8'h00; frc = 1'b0;

      // Reset, slow comma lock, resync, broken comma run, idle tracking, held resync.
      repeat (3) add(1, 0, 8'h00, 0, 0, 0, 0, 2'd0, 3'd0, 8'd0);
      add(0, 1, COM, 0, 7, 0, 0, 2'd0, 3'd1, 8'd0);
      add(0, 1, COM, 0, 7, 0, 0, 2'd0, 3'd2, 8'd0);
      add(0, 1, COM, 0, 7, 0, 0, 2'd0, 3'd3, 8'd0);
      add(0, 1, COM, 0, 7, 1, 0, 2'd1, 3'd0, 8'd0);
      add(0, 0, 8'h00, 1, 0, 0, 0, 2'd0, 3'd0, 8'd1);
      add(0, 0, 8'h00, 0, 0, 0, 0, 2'd0, 3'd0, 8'd1);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd1, 8'd1);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd2, 8'd1);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd3, 8'd1);
      add(0, 1, 8'h55, 0, 0, 0, 0, 2'd0, 3'd0, 8'd1);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd1, 8'd1);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd2, 8'd1);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd3, 8'd1);
      add(0, 1, COM, 0, 0, 1, 0, 2'd1, 3'd0, 8'd1);
      add(0, 1, IDL, 0, 0, 1, 1, 2'd2, 3'd0, 8'd1);
      add(0, 1, IDL, 0, 0, 1, 1, 2'd2, 3'd0, 8'd1);
      add(0, 1, 8'hA5, 0, 0, 1, 0, 2'd1, 3'd0, 8'd1);
      add(0, 1, COM, 0, 0, 1, 0, 2'd1, 3'd0, 8'd1);
      add(0, 0, 8'h00, 1, 0, 0, 0, 2'd0, 3'd0, 8'd2);
      repeat (8) add(0, 1, COM, 1, 0, 0, 0, 2'd0, 3'd0, 8'd2);
      add(0, 0, 8'h00, 0, 0, 0, 0, 2'd0, 3'd0, 8'd2);
      add(0, 1, COM, 0, 0, 0, 0, 2'd0, 3'd1, 8'd2);
      add(0, 1, IDL, 0, 0, 0, 0, 2'd0, 3'd0, 8'd2);

      for (int k = 0; k < tbl.size(); k++) begin
         cyc(tbl[k].rst, tbl[k].vld, tbl[k].dat, tbl[k].frc);
         chk($sformatf("vec%0d", k), got(),
             pk(tbl[k].e_act, tbl[k].e_idl, !tbl[k].e_act, tbl[k].e_st, tbl[k].e_cnt, tbl[k].e_rs));
         for (int g = 0; g < tbl[k].gap; g++) cyc(1'b0, 1'b0, 8'h00, tbl[k].frc);
      end

      // Timeout: 31 silent cycles keep lock, the 32nd drops it.
      lock4();
      chk_exp("t5_lock", 1, 0, 2'd1, 3'd0, 8'd2);
      repeat (TMO - 1) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_exp("t5_hold31", 1, 0, 2'd1, 3'd0, 8'd2);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_exp("t5_timeout", 0, 0, 2'd0, 3'd0, 8'd3);

      // Strobe on the final timer cycle rescues the lock.
      lock4();
      repeat (TMO - 1) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk_exp("t5_rescue", 1, 0, 2'd1, 3'd0, 8'd3);
      repeat (TMO - 1) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_exp("t5_rescue_hold", 1, 0, 2'd1, 3'd0, 8'd3);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_exp("t5_timeout2", 0, 0, 2'd0, 3'd0, 8'd4);

      // Resync from IDLE, then reset mid-lock clears the loss count without counting.
      lock4();
      cyc(1'b0, 1'b1, IDL, 1'b0);
      chk_exp("idle_enter", 1, 1, 2'd2, 3'd0, 8'd4);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk_exp("idle_resync", 0, 0, 2'd0, 3'd0, 8'd5);
      lock4();
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk_exp("reset_midlock", 0, 0, 2'd0, 3'd0, 8'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_exp("reset_after", 0, 0, 2'd0, 3'd0, 8'd0);

      // Loss counter saturation.
      for (int i = 0; i < 260; i++) begin
         lock4();
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         if (i == 253) chk_exp("sat_254", 0, 0, 2'd0, 3'd0, 8'd254);
         if (i == 254) chk_exp("sat_255", 0, 0, 2'd0, 3'd0, 8'd255);
      end
      chk_exp("sat_hold", 0, 0, 2'd0, 3'd0, 8'd255);

      // Random traffic in segments of differing strobe density.
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("rand_reset", got(), model_exp());
      for (int seg = 0; seg < 40; seg++) begin
         int p;
         case ($urandom_range(0, 2))
            0:       p = 90;
            1:       p = 40;
            default: p = 3;
         endcase
         for (int c = 0; c < 64; c++) begin
            logic       r_vld, r_frc, r_rst;
            logic [7:0] r_dat;
            int         sel;
            r_vld = ($urandom_range(0, 99) < p);
            sel   = $urandom_range(0, 9);
            r_dat = (sel < 6) ? COM : (sel < 8) ? IDL : 8'($urandom_range(0, 255));
            r_frc = ($urandom_range(0, 199) == 0);
            r_rst = ($urandom_range(0, 999) == 0);
            cyc(r_rst, r_vld, r_dat, r_frc);
            chk($sformatf("rand_s%0d_c%0d", seg, c), got(), model_exp());
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
